// File: rtl/logic_func0_tester.sv
// rtl/logic_func0_tester.sv - self-test driver for 4-input logic function blocks
// Sweeps {p,q,r,s} through 0..15, samples f_in per vector and grades the truth table.
module logic_func0_tester #(
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [15:0] EXPECTED_TT   = 16'hF888
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
  output logic        p,
  output logic        q,
  output logic        r,
  output logic        s,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  fail_count,
  output logic [3:0]  first_fail_idx,
  output logic [15:0] captured_tt
);

  // Settle counter only has to reach SETTLE_CYCLES-1.
  localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, FINISHED} state_t;

  state_t        state;
  logic [3:0]    idx;
  logic [SW-1:0] settle;
  logic [15:0]   next_tt;
  logic          mismatch;

  // The stimulus is the vector index register itself, so it stays registered.
  assign {p, q, r, s} = idx;

  always_comb begin
    next_tt      = captured_tt;
    next_tt[idx] = f_in;
    mismatch     = (f_in != EXPECTED_TT[idx]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= 4'd0;
      settle         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_count     <= 5'd0;
      first_fail_idx <= 4'd0;
      captured_tt    <= 16'd0;
    end else begin
      case (state)
        IDLE, FINISHED: begin
          if (start) begin
            state          <= DRIVE;
            idx            <= 4'd0;
            settle         <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail_count     <= 5'd0;
            first_fail_idx <= 4'd0;
            captured_tt    <= 16'd0;
          end
        end
        DRIVE: begin
          if (settle == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        SAMPLE: begin
          captured_tt <= next_tt;
          if (mismatch) begin
            fail_count <= fail_count + 5'd1;
            if (fail_count == 5'd0) begin
              first_fail_idx <= idx;
            end
          end
          // Leaving at 15 instead of wrapping keeps every vector single-shot.
          if (idx == 4'd15) begin
            state <= FINISHED;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (next_tt == EXPECTED_TT);
          end else begin
            state  <= DRIVE;
            idx    <= idx + 4'd1;
            settle <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_func0_tester.sv
// tb/tb_logic_func0_tester.sv - directed bench for logic_func0_tester
// Default-parameter instance plus a SETTLE_CYCLES=1 instance.
module tb_logic_func0_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic start1 = 1'b0;
  int   mode = 0;
  int   errs = 0;
  int   n_checks = 0;

  logic        p, q, r, s, busy, done, pass, f_in;
  logic [4:0]  fail_count;
  logic [3:0]  first_fail_idx;
  logic [15:0] captured_tt;

  logic        p1, q1, r1, s1, busy1, done1, pass1, f_in1;
  logic [4:0]  fail_count1;
  logic [3:0]  first_fail_idx1;
  logic [15:0] captured_tt1;

  always #5 clk = ~clk;

  // mode 0: correct function, 1: tied low, 2: inverted
  assign f_in  = (mode == 0) ? ((p & q) | (r & s)) :
                 (mode == 1) ? 1'b0 : ~((p & q) | (r & s));
  assign f_in1 = (p1 & q1) | (r1 & s1);

  logic_func0_tester dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in),
    .p(p), .q(q), .r(r), .s(s), .busy(busy), .done(done), .pass(pass),
    .fail_count(fail_count), .first_fail_idx(first_fail_idx), .captured_tt(captured_tt)
  );

  logic_func0_tester #(.SETTLE_CYCLES(1), .EXPECTED_TT(16'hF888)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f_in1),
    .p(p1), .q(q1), .r(r1), .s(s1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_count(fail_count1), .first_fail_idx(first_fail_idx1), .captured_tt(captured_tt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulses start, optionally re-pulses at edge count 'repulse', returns edge count at done.
  task automatic run(input int repulse, input bit chk_vec, output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (chk_vec)
        check("vec", {27'd0, busy, p, q, r, s}, {27'd0, 1'b1, 4'((cyc - 1) / 3)});
      start = (cyc == repulse);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic check_results(input string tag, input logic [15:0] tt, input logic ps,
                               input logic [4:0] fc, input logic [3:0] ffi);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_tt"}, {16'd0, captured_tt}, {16'd0, tt});
    check({tag, "_pass"}, {31'd0, pass}, {31'd0, ps});
    check({tag, "_fc"}, {27'd0, fail_count}, {27'd0, fc});
    if (fc != 5'd0)
      check({tag, "_ffi"}, {28'd0, first_fail_idx}, {28'd0, ffi});
    check({tag, "_stim"}, {28'd0, p, q, r, s}, 32'hF);
  endtask

  initial begin
    int cyc;
    logic [31:0] all_out;

    // Reset state
    repeat (2) @(negedge clk);
    all_out = {busy, done, pass, p, q, r, s, fail_count, first_fail_idx, captured_tt};
    check("reset_outs", all_out, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_outs", {busy, done, pass, p, q, r, s, fail_count, first_fail_idx, captured_tt}, 32'd0);

    // 1: correct function
    mode = 0;
    run(-1, 1'b1, cyc);
    check("t1_cycle", cyc, 49);
    check_results("t1", 16'hF888, 1'b1, 5'd0, 4'd0);
    repeat (3) @(negedge clk);
    check("t1_hold", {busy, done, pass, captured_tt}, {3'b011, 16'hF888});

    // 2: tied low
    mode = 1;
    run(-1, 1'b0, cyc);
    check("t2_cycle", cyc, 49);
    check_results("t2", 16'h0000, 1'b0, 5'd7, 4'd3);

    // 3: inverted
    mode = 2;
    run(-1, 1'b0, cyc);
    check("t3_cycle", cyc, 49);
    check_results("t3", 16'h0777, 1'b0, 5'd16, 4'd0);

    // 4: start re-pulsed during vector 4 is ignored
    mode = 0;
    run(13, 1'b1, cyc);
    check("t4_cycle", cyc, 49);
    check_results("t4", 16'hF888, 1'b1, 5'd0, 4'd0);
    // start while in DONE restarts and clears results
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_restart", {busy, done, pass, p, q, r, s, fail_count, first_fail_idx, captured_tt},
          {3'b100, 29'd0});
    cyc = 1;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("t4_rerun_cycle", cyc, 49);
    check_results("t4b", 16'hF888, 1'b1, 5'd0, 4'd0);

    // 5: reset during vector 5 (edges 15..17)
    mode = 2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    check("t5_pre_vec", {28'd0, p, q, r, s}, 32'd5);
    check("t5_pre_fc", {27'd0, fail_count}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_outs", {busy, done, pass, p, q, r, s, fail_count, first_fail_idx, captured_tt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_idle", {busy, done, p, q, r, s}, 32'd0);
    mode = 0;
    run(-1, 1'b1, cyc);
    check("t5_cycle", cyc, 49);
    check_results("t5", 16'hF888, 1'b1, 5'd0, 4'd0);

    // 6: SETTLE_CYCLES=1 instance
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    cyc = 1;
    while (!done1 && cyc < 200) begin
      check("t6_vec", {27'd0, busy1, p1, q1, r1, s1}, {27'd0, 1'b1, 4'((cyc - 1) / 2)});
      @(negedge clk);
      cyc++;
    end
    check("t6_cycle", cyc, 33);
    check("t6_pass", {31'd0, pass1}, 32'd1);
    check("t6_tt", {16'd0, captured_tt1}, 32'h0000F888);
    check("t6_fc", {27'd0, fail_count1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, n_checks);
    $finish;
  end

endmodule
